// File: rtl/iter_divider.sv
// Iterative restoring divide/remainder unit for RV64M execute.
// Handles DIV/DIVU/REM/REMU and their W-mode variants with valid/ready and flush.
module iter_divider #(
  parameter int WIDTH     = 64,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op_w,
  input  logic             op_rem,
  input  logic             op_unsigned,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int HALF = WIDTH / 2;
  localparam int RW   = WIDTH + STEP_BITS;
  localparam int CW   = $clog2(WIDTH / STEP_BITS);
  localparam logic [CW-1:0] LAST_F = CW'(WIDTH / STEP_BITS - 1);
  localparam logic [CW-1:0] LAST_W = CW'(HALF / STEP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_RUN, S_FIX, S_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] quo, div;
  logic [RW-1:0]    rem_q;
  logic [CW-1:0]    cnt;
  logic             w_q, rem_q_sel, uns_q;
  logic             q_neg, r_neg;

  logic             accept;
  logic             last;
  logic [WIDTH-1:0] a_ext, b_ext, a_sx, min_ext;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sa, sb;
  logic             b_zero, ovf, special;
  logic [WIDTH-1:0] spec_res;
  logic [WIDTH-1:0] q_step;
  logic [RW-1:0]    r_step;
  logic [WIDTH-1:0] q_val, r_val, sel, fix_res;

  assign in_ready  = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready & ~flush;
  assign last      = (cnt == (w_q ? LAST_W : LAST_F));

  // Operand conditioning for the PREP cycle
  always_comb begin
    a_sx = w_q ? {{HALF{a_q[HALF-1]}}, a_q[HALF-1:0]} : a_q;
    if (w_q && uns_q) begin
      a_ext = {{HALF{1'b0}}, a_q[HALF-1:0]};
      b_ext = {{HALF{1'b0}}, b_q[HALF-1:0]};
    end else if (w_q) begin
      a_ext = a_sx;
      b_ext = {{HALF{b_q[HALF-1]}}, b_q[HALF-1:0]};
    end else begin
      a_ext = a_q;
      b_ext = b_q;
    end
    min_ext = w_q ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}}
                  : {1'b1, {(WIDTH-1){1'b0}}};
    sa      = ~uns_q & a_ext[WIDTH-1];
    sb      = ~uns_q & b_ext[WIDTH-1];
    mag_a   = sa ? -a_ext : a_ext;
    mag_b   = sb ? -b_ext : b_ext;
    b_zero  = (b_ext == '0);
    ovf     = ~uns_q & (a_ext == min_ext) & (b_ext == '1);
    special = b_zero | ovf;
    if (b_zero) spec_res = rem_q_sel ? a_sx : '1;
    else        spec_res = rem_q_sel ? '0 : a_ext;
  end

  // STEP_BITS restoring iterations per RUN cycle
  always_comb begin
    q_step = quo;
    r_step = rem_q;
    for (int i = 0; i < STEP_BITS; i++) begin
      r_step = {r_step[RW-2:0], q_step[WIDTH-1]};
      q_step = {q_step[WIDTH-2:0], 1'b0};
      if (r_step >= {{STEP_BITS{1'b0}}, div}) begin
        r_step    = r_step - {{STEP_BITS{1'b0}}, div};
        q_step[0] = 1'b1;
      end
    end
  end

  always_comb begin
    q_val   = q_neg ? -quo : quo;
    r_val   = r_neg ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    sel     = rem_q_sel ? r_val : q_val;
    fix_res = w_q ? {{HALF{sel[HALF-1]}}, sel[HALF-1:0]} : sel;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_PREP;
      S_PREP: state_nx = special ? S_DONE : S_RUN;
      S_RUN:  if (last) state_nx = S_FIX;
      S_FIX:  state_nx = S_DONE;
      S_DONE: if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q       <= '0;
      b_q       <= '0;
      w_q       <= 1'b0;
      rem_q_sel <= 1'b0;
      uns_q     <= 1'b0;
      quo       <= '0;
      div       <= '0;
      rem_q     <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      result    <= '0;
    end else begin
      if (accept) begin
        a_q       <= a;
        b_q       <= b;
        w_q       <= op_w;
        rem_q_sel <= op_rem;
        uns_q     <= op_unsigned;
      end
      unique case (state)
        S_PREP: begin
          quo   <= w_q ? {mag_a[HALF-1:0], {HALF{1'b0}}} : mag_a;
          div   <= mag_b;
          rem_q <= '0;
          cnt   <= '0;
          q_neg <= sa ^ sb;
          r_neg <= sa;
          if (special && !flush) result <= spec_res;
        end
        S_RUN: begin
          quo   <= q_step;
          rem_q <= r_step;
          cnt   <= last ? '0 : cnt + CW'(1);
        end
        S_FIX: if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

endmodule
